tank_mover: RTL
===============

# tank_mover

Parametrised player-tank motion and life controller, the successor to the fixed-constant per-player tank blocks. One instance per player. It decodes the keyboard keycode into saturating, bounded motion and reports facing direction to the sprite and projectile logic. On top of the earlier blocks it adds a lives counter, a post-hit freeze and respawn, an invulnerability window and a game-over state. Key mapping, arena bounds, spawn point, speed and timers are all parameters, so both players share this one block.

## Interface
- X_CENTER, 480: spawn X (pixel, tank centre)
- Y_CENTER, 240: spawn Y
- X_MIN, 0 / X_MAX, 639: horizontal arena bounds, inclusive
- Y_MIN, 0 / Y_MAX, 479: vertical arena bounds, inclusive
- SIZE, 4: half-width of the tank, driven on BallS
- STEP, 1: pixels moved per frame
- KEY_LEFT, 80 / KEY_RIGHT, 79 / KEY_DOWN, 81 / KEY_UP, 82: keycodes for each direction
- LIVES, 3: starting lives, range 1..15
- FREEZE_FRAMES, 60: frames frozen after a hit, ≥1
- INVULN_FRAMES, 120: frames of hit immunity after the freeze ends, ≥1
- Parameter constraints: X_MIN+SIZE ≤ X_CENTER ≤ X_MAX−SIZE, and the same rule for Y.

Ports:
- frame_clk  in  1  frame clock; the single clock for the block
- Reset_n  in  1  asynchronous, active-low reset
- was_hit  in  1  hit strobe, sampled on frame_clk (no longer an async reset)
- keycode  in  8  current key
- BallX, BallY  out  10  tank centre position
- BallS  out  10  constant SIZE
- direction  out  2  facing: 00 left, 01 right, 10 down, 11 up
- lives_left  out  4  remaining lives
- alive  out  1  high in the ALIVE and INVULN states
- invuln  out  1  high in the INVULN state (used for sprite blink)
- game_over  out  1  high in the DEAD state

## Operation
- States: ALIVE, FREEZE, INVULN, DEAD. A down-counter `cnt` serves the FREEZE and INVULN states.
- Reset (Reset_n=0, takes effect immediately):
  - state=ALIVE, BallX=X_CENTER, BallY=Y_CENTER, direction=00, lives_left=LIVES, cnt=0.
  - Outputs: alive=1, invuln=0, game_over=0.
- Motion (ALIVE and INVULN only):
  - Direction keys:
    - KEY_LEFT: X ← max(X−STEP, X_MIN+SIZE).
    - KEY_RIGHT: X ← min(X+STEP, X_MAX−SIZE).
    - KEY_DOWN: Y ← min(Y+STEP, Y_MAX−SIZE).
    - KEY_UP: Y ← max(Y−STEP, Y_MIN+SIZE).
  - direction updates on any of the four keys, even when the move is clamped to zero.
  - Any other keycode: position and direction are held.
  - Arithmetic is done in 11-bit signed, so subtracting near 0 cannot wrap. The tank never leaves [MIN+SIZE, MAX−SIZE].
  - Only one axis moves per frame. There is no separate motion register, so the position step applies on the same edge that samples the key.
- ALIVE state, was_hit=1:
  - Hit takes priority over a key in the same cycle; the tank does not move.
  - lives_left decrements, position returns to the spawn point, direction resets to 00.
  - If lives_left was 1, the next state is DEAD.
  - Otherwise the next state is FREEZE with cnt=FREEZE_FRAMES−1.
- FREEZE state:
  - Keys and hits are ignored and the position is held at spawn.
  - cnt decrements each frame. On the edge where cnt==0, go to INVULN with cnt=INVULN_FRAMES−1.
- INVULN state:
  - Motion is enabled and hits are ignored.
  - cnt decrements each frame. On the edge where cnt==0, go to ALIVE.
- DEAD state:
  - Position stays at spawn and direction at 00.
  - Keys and hits are ignored; only Reset_n leaves this state.
- lives_left never underflows. A hit in DEAD has no effect.

## Timing
- All outputs are registered and change only on the rising edge of frame_clk, or asynchronously on reset.
- Key→position latency: a key sampled at edge k appears on BallX/BallY after edge k.
- Hit→respawn: a hit at edge k gives spawn position, lives_left−1 and alive=0 after edge k.
- Freeze length: alive stays 0 for exactly FREEZE_FRAMES frames.
- Invulnerability length: invuln stays 1 for exactly INVULN_FRAMES frames, then drops to 0.
- A Reset_n assertion in any state, including mid-countdown, returns every output to its reset value immediately. Release is synchronised to the next edge.

## Test plan
- Reset, then hold keycode=80 for 10 frames: BallX=470, BallY=240, direction=00.
- Use X_MIN=0, SIZE=4, STEP=3 and hold keycode=80 from X=9: the sequence is 6, then 4, then held at 4. direction=00 throughout and no wrap to ~1020.
- Hold keycode=82 while at the top bound (Y=4): Y holds at 4 and direction becomes 11.
- Apply a was_hit pulse and keycode=79 in the same frame at X=500:
  - After the edge: X=480, lives_left=2, alive=0.
  - After 60 frames: invuln=1.
  - A hit during INVULN leaves lives_left=2.
  - After a further 120 frames: invuln=0.
- Three hits, each taken after the tank returns to ALIVE: lives_left=0, game_over=1. Further keys and hits leave X=480, Y=240.
- Assert Reset_n low mid-FREEZE with cnt=30: state returns to ALIVE with lives_left=3, alive=1, invuln=0, game_over=0 immediately.

Source files
------------

// File: rtl/tank_mover_if.sv
`default_nettype none
// ============================================================================
//  Module      : tank_mover_if
//  Description : Key/hit inputs and position/status outputs of one tank.
//  Revision    : 1.0 - initial release
// ============================================================================
interface tank_mover_if;
   logic       was_hit;
   logic [7:0] keycode;
   logic [9:0] BallX;
   logic [9:0] BallY;
   logic [9:0] BallS;
   logic [1:0] direction;
   logic [3:0] lives_left;
   logic       alive;
   logic       invuln;
   logic       game_over;

   modport master (
      output was_hit, keycode,
      input  BallX, BallY, BallS, direction, lives_left, alive, invuln, game_over
   );

   modport slave (
      input  was_hit, keycode,
      output BallX, BallY, BallS, direction, lives_left, alive, invuln, game_over
   );
endinterface
`default_nettype wire

// File: rtl/tank_mover.sv
`default_nettype none
// ============================================================================
//  Module      : tank_mover
//  Description : Bounded keyboard motion plus lives/freeze/invuln/dead control.
//  Revision    : 1.0 - initial release
// ============================================================================
module tank_mover #(
   parameter int X_CENTER      = 480,
   parameter int Y_CENTER      = 240,
   parameter int X_MIN         = 0,
   parameter int X_MAX         = 639,
   parameter int Y_MIN         = 0,
   parameter int Y_MAX         = 479,
   parameter int SIZE          = 4,
   parameter int STEP          = 1,
   parameter int KEY_LEFT      = 80,
   parameter int KEY_RIGHT     = 79,
   parameter int KEY_DOWN      = 81,
   parameter int KEY_UP        = 82,
   parameter int LIVES         = 3,
   parameter int FREEZE_FRAMES = 60,
   parameter int INVULN_FRAMES = 120
) (
   input  wire logic       frame_clk,
   input  wire logic       Reset_n,
   tank_mover_if.slave     bus
);

   localparam int c_CNT_MAX = (FREEZE_FRAMES > INVULN_FRAMES) ? FREEZE_FRAMES : INVULN_FRAMES;
   localparam int c_CNT_W   = (c_CNT_MAX < 2) ? 1 : $clog2(c_CNT_MAX);

   localparam logic [1:0] c_ST_ALIVE  = 2'd0;
   localparam logic [1:0] c_ST_FREEZE = 2'd1;
   localparam logic [1:0] c_ST_INVULN = 2'd2;
   localparam logic [1:0] c_ST_DEAD   = 2'd3;

   localparam logic [1:0] c_DIR_LEFT  = 2'b00;
   localparam logic [1:0] c_DIR_RIGHT = 2'b01;
   localparam logic [1:0] c_DIR_DOWN  = 2'b10;
   localparam logic [1:0] c_DIR_UP    = 2'b11;

   localparam logic [9:0] c_X_SPAWN = 10'(X_CENTER);
   localparam logic [9:0] c_Y_SPAWN = 10'(Y_CENTER);

   // Clamp limits in 11-bit signed so a step below zero compares as negative
   localparam logic signed [10:0] c_X_LO = 11'(X_MIN + SIZE);
   localparam logic signed [10:0] c_X_HI = 11'(X_MAX - SIZE);
   localparam logic signed [10:0] c_Y_LO = 11'(Y_MIN + SIZE);
   localparam logic signed [10:0] c_Y_HI = 11'(Y_MAX - SIZE);
   localparam logic signed [10:0] c_STEP = 11'(STEP);

   localparam logic [c_CNT_W-1:0] c_FREEZE_LOAD = c_CNT_W'(FREEZE_FRAMES - 1);
   localparam logic [c_CNT_W-1:0] c_INVULN_LOAD = c_CNT_W'(INVULN_FRAMES - 1);

   logic [1:0]         r_state;
   logic [9:0]         r_x;
   logic [9:0]         r_y;
   logic [1:0]         r_dir;
   logic [3:0]         r_lives;
   logic [c_CNT_W-1:0] r_cnt;

   logic [1:0]         w_state_nxt;
   logic [9:0]         w_x_nxt;
   logic [9:0]         w_y_nxt;
   logic [1:0]         w_dir_nxt;
   logic [3:0]         w_lives_nxt;
   logic [c_CNT_W-1:0] w_cnt_nxt;
   logic               w_move_en;

   logic signed [10:0] w_left;
   logic signed [10:0] w_right;
   logic signed [10:0] w_down;
   logic signed [10:0] w_up;
   logic signed [10:0] w_left_cl;
   logic signed [10:0] w_right_cl;
   logic signed [10:0] w_down_cl;
   logic signed [10:0] w_up_cl;

   assign w_left     = $signed({1'b0, r_x}) - c_STEP;
   assign w_right    = $signed({1'b0, r_x}) + c_STEP;
   assign w_down     = $signed({1'b0, r_y}) + c_STEP;
   assign w_up       = $signed({1'b0, r_y}) - c_STEP;
   assign w_left_cl  = (w_left  < c_X_LO) ? c_X_LO : w_left;
   assign w_right_cl = (w_right > c_X_HI) ? c_X_HI : w_right;
   assign w_down_cl  = (w_down  > c_Y_HI) ? c_Y_HI : w_down;
   assign w_up_cl    = (w_up    < c_Y_LO) ? c_Y_LO : w_up;

   always_ff @(posedge frame_clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state <= c_ST_ALIVE;
         r_x     <= c_X_SPAWN;
         r_y     <= c_Y_SPAWN;
         r_dir   <= c_DIR_LEFT;
         r_lives <= 4'(LIVES);
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_x     <= w_x_nxt;
         r_y     <= w_y_nxt;
         r_dir   <= w_dir_nxt;
         r_lives <= w_lives_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_x_nxt     = r_x;
      w_y_nxt     = r_y;
      w_dir_nxt   = r_dir;
      w_lives_nxt = r_lives;
      w_cnt_nxt   = r_cnt;
      w_move_en   = 1'b0;

      case (r_state)
         c_ST_ALIVE: begin
            // A hit wins over any key sampled on the same edge
            if (bus.was_hit) begin
               w_lives_nxt = (r_lives != 4'd0) ? r_lives - 4'd1 : 4'd0;
               w_x_nxt     = c_X_SPAWN;
               w_y_nxt     = c_Y_SPAWN;
               w_dir_nxt   = c_DIR_LEFT;
               if (r_lives <= 4'd1) begin
                  w_state_nxt = c_ST_DEAD;
               end else begin
                  w_state_nxt = c_ST_FREEZE;
                  w_cnt_nxt   = c_FREEZE_LOAD;
               end
            end else begin
               w_move_en = 1'b1;
            end
         end
         c_ST_FREEZE: begin
            if (r_cnt == '0) begin
               w_state_nxt = c_ST_INVULN;
               w_cnt_nxt   = c_INVULN_LOAD;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         c_ST_INVULN: begin
            w_move_en = 1'b1;
            if (r_cnt == '0) begin
               w_state_nxt = c_ST_ALIVE;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         default: begin
            w_state_nxt = c_ST_DEAD;
         end
      endcase

      if (w_move_en) begin
         if (bus.keycode == 8'(KEY_LEFT)) begin
            w_x_nxt   = w_left_cl[9:0];
            w_dir_nxt = c_DIR_LEFT;
         end else if (bus.keycode == 8'(KEY_RIGHT)) begin
            w_x_nxt   = w_right_cl[9:0];
            w_dir_nxt = c_DIR_RIGHT;
         end else if (bus.keycode == 8'(KEY_DOWN)) begin
            w_y_nxt   = w_down_cl[9:0];
            w_dir_nxt = c_DIR_DOWN;
         end else if (bus.keycode == 8'(KEY_UP)) begin
            w_y_nxt   = w_up_cl[9:0];
            w_dir_nxt = c_DIR_UP;
         end
      end
   end

   always_comb begin
      bus.alive     = (r_state == c_ST_ALIVE) || (r_state == c_ST_INVULN);
      bus.invuln    = (r_state == c_ST_INVULN);
      bus.game_over = (r_state == c_ST_DEAD);
   end

   assign bus.BallX      = r_x;
   assign bus.BallY      = r_y;
   assign bus.BallS      = 10'(SIZE);
   assign bus.direction  = r_dir;
   assign bus.lives_left = r_lives;

endmodule
`default_nettype wire
